// File: rtl/win3_feeder.sv
// win3_feeder: builds 3-sample windows (sliding or block stride) for the 3-input sorter.
// Latency: triple valid the cycle after the accept that completes the window; short_frame likewise.
// Backpressure: single output slot, in_ready = !out_valid || out_ready (no skid, nothing dropped).
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_data/in_last sample stream;
//        out_valid/out_ready/out_a/out_b/out_c/out_last window triple; short_frame pulse.
module win3_feeder #(
  parameter int SNG_WIDTH  = 4,
  parameter bit BLOCK_MODE = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SNG_WIDTH-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SNG_WIDTH-1:0] out_a,
  output logic [SNG_WIDTH-1:0] out_b,
  output logic [SNG_WIDTH-1:0] out_c,
  output logic                 out_last,
  output logic                 short_frame
);

  // Only the two newest window slots are kept: when a window completes, its
  // oldest member is the pre-shift w1 and the slot beyond it is never read.
  logic [SNG_WIDTH-1:0] w1_q, w1_d;
  logic [SNG_WIDTH-1:0] w2_q, w2_d;
  logic [1:0]           fill_q, fill_d;
  logic [SNG_WIDTH-1:0] out_a_q, out_a_d;
  logic [SNG_WIDTH-1:0] out_b_q, out_b_d;
  logic [SNG_WIDTH-1:0] out_c_q, out_c_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic                 short_frame_q, short_frame_d;

  logic                 accept;
  logic                 emit;
  logic [1:0]           fill_inc;

  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    accept   = in_valid && in_ready;
    fill_inc = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
    emit     = accept && (fill_inc == 2'd3);

    w1_d          = w1_q;
    w2_d          = w2_q;
    fill_d        = fill_q;
    out_a_d       = out_a_q;
    out_b_d       = out_b_q;
    out_c_d       = out_c_q;
    out_last_d    = out_last_q;
    out_valid_d   = out_valid_q && !out_ready;
    short_frame_d = 1'b0;

    if (accept) begin
      w1_d = w2_q;
      w2_d = in_data;
      // A frame end always empties the window so no window spans two frames;
      // block mode also restarts after every emitted window.
      if (in_last || (BLOCK_MODE && emit)) begin
        fill_d = 2'd0;
      end else begin
        fill_d = fill_inc;
      end
      short_frame_d = in_last && !emit;
    end

    // emit implies accept, which implies the output slot is free this cycle.
    if (emit) begin
      out_a_d     = w1_q;
      out_b_d     = w2_q;
      out_c_d     = in_data;
      out_valid_d = 1'b1;
      out_last_d  = in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w1_q          <= '0;
      w2_q          <= '0;
      fill_q        <= 2'd0;
      out_a_q       <= '0;
      out_b_q       <= '0;
      out_c_q       <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      short_frame_q <= 1'b0;
    end else begin
      w1_q          <= w1_d;
      w2_q          <= w2_d;
      fill_q        <= fill_d;
      out_a_q       <= out_a_d;
      out_b_q       <= out_b_d;
      out_c_q       <= out_c_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      short_frame_q <= short_frame_d;
    end
  end

  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_c       = out_c_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign short_frame = short_frame_q;

endmodule

// File: doc/win3_feeder.md
# win3_feeder

Sample-stream windowing stage directly upstream of the three-input compare-and-swap sorter. Accepts a serial stream of `SNG_WIDTH`-bit samples over a valid/ready handshake. Assembles three-sample windows, either sliding (stride 1) or non-overlapping (stride 3), and presents each window as a registered triple (`out_a`, `out_b`, `out_c`) for the sorter's `a`, `b` and `c` inputs. Frame boundaries are marked with `in_last`; a window never spans two frames.

## Interface

- `SNG_WIDTH`, 4, sample width in bits.
- `BLOCK_MODE`, 0, window stride: 0 = sliding (stride 1), 1 = block (stride 3, non-overlapping).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  upstream sample valid.
- `in_ready`  out  1  stage can accept a sample.
- `in_data`  in  SNG_WIDTH  sample value, unsigned.
- `in_last`  in  1  qualifies `in_data` as the last sample of its frame.
- `out_valid`  out  1  window triple valid.
- `out_ready`  in  1  downstream accepts the triple.
- `out_a`  out  SNG_WIDTH  oldest sample of the window.
- `out_b`  out  SNG_WIDTH  middle sample of the window.
- `out_c`  out  SNG_WIDTH  newest sample of the window.
- `out_last`  out  1  window contains the frame's last sample.
- `short_frame`  out  1  one-cycle pulse: the frame ended with leftover samples that formed no window.

## Operation

- **State**
  - Window registers `w0` (oldest), `w1`, `w2` (newest).
  - Fill counter `fill`, range 0..3, 2 bits.
  - Output registers for the triple, `out_valid` and `out_last`.
- **Accept rule**
  - A sample is accepted when `in_valid && in_ready`.
  - `in_ready = !out_valid || out_ready` (combinational; single output slot, no skid).
- **On accept**
  - Shift `w0 <= w1`, `w1 <= w2`, `w2 <= in_data`.
  - `fill_next = min(fill + 1, 3)`.
- **Window emit** (when `fill_next == 3`)
  - Load outputs: `out_a` = old `w1`, `out_b` = old `w2`, `out_c` = `in_data`.
  - Set `out_valid <= 1` and `out_last <= in_last`.
- **Fill update after accept**
  - `in_last` accepted: `fill <= 0` (window cleared).
  - Otherwise, `BLOCK_MODE = 1` and a window was emitted: `fill <= 0`.
  - Otherwise: `fill <= fill_next`, saturating at 3 in sliding mode.
- **Short frame**
  - Condition: `in_last` accepted with `fill_next < 3`.
  - Covers a frame shorter than 3 samples, and a block-mode remainder of 1 or 2.
  - Leftover samples are discarded, no window is emitted, and `short_frame` is 1 in the next cycle only.
- **Output hold**
  - While `out_valid && !out_ready`, the triple and `out_last` are held stable.
- **Output drain**
  - On `out_valid && out_ready` with no new emit that cycle: `out_valid <= 0`.
- **Simultaneous consume and emit**
  - Downstream consumes and a new window is emitted in the same cycle: `out_valid` stays 1 and the outputs take the new window.
- **No arithmetic on samples**
  - Values pass through unmodified; ordering is left to the sorter.
- **States** (encoded by `fill` and `out_valid`)
  - EMPTY (`fill` = 0), PART1 (1), PART2 (2), FULL (3, sliding mode only).
  - Transitions occur only on accept, as above.
  - Backpressure is orthogonal to these states.

## Timing

- **Reset** (synchronous, wins over all other activity)
  - Outputs: `out_valid` = 0, `out_a`/`out_b`/`out_c` = 0, `out_last` = 0, `short_frame` = 0, `fill` = 0, window registers 0.
  - `in_ready` = 1 in the first cycle after reset.
- **Latency**
  - The triple is valid in the cycle after the accept of the sample that completes the window.
  - `short_frame` is asserted in the cycle after the accept of the `in_last` sample.
- **Throughput**
  - Sliding mode: one window per cycle once `fill` = 3 with continuous `in_valid` and `out_ready`.
  - Block mode: one window per three accepts.
- **Reset mid-operation**
  - A partial window and a pending output are dropped; no partial output.
  - The next window is built only from samples accepted after reset.
- **`out_ready` timing**
  - `out_ready` may be low indefinitely; no sample is lost or duplicated.
- **Combinational paths**
  - `in_ready` is the only combinational output (from `out_valid` and `out_ready`).
- **Upstream obligation**
  - `in_valid` and `in_data` must remain stable until accepted.

## Test plan

- **Sliding stream:** `BLOCK_MODE`=0, samples 1,2,3,4,5 with `in_last` on 5, `out_ready`=1.
  - Windows (1,2,3), (2,3,4), (3,4,5) with `out_last`=1 only on the third.
  - Each window valid the cycle after accepts of 3, 4 and 5.
- **Backpressure:** hold `out_ready`=0 for 3 cycles while window (1,2,3) is valid.
  - `in_ready`=0 and the triple is stable throughout.
  - After release, the next sample 4 yields (2,3,4) with no loss.
- **Short frame then new frame:** 7, 9 with `in_last` on 9.
  - No output; `short_frame` pulses once.
  - Next frame 1,2,3 yields (1,2,3), not (9,1,2).
- **Block mode remainder:** `BLOCK_MODE`=1, samples 1..7 with `in_last` on 7.
  - Outputs (1,2,3) and (4,5,6), both with `out_last`=0.
  - Sample 7 is discarded and `short_frame` pulses.
- **Reset mid-fill:** accept 8, 9, assert `rst` for one cycle, then accept 1, 2, 3.
  - Exactly one window (1,2,3); all outputs 0 in the cycle after `rst`.
- **Full throughput:** continuous `in_valid`, `out_ready`=1, 0..15 values.
  - After the first window, `out_valid` stays 1 every cycle and `in_ready` stays 1.
  - Window contents match a golden shift-register model.
